// File: rtl/fetch_request_sequencer_if.sv
// Fetch request sequencer bus bundle.
//
// Groups the fetch-side and instruction-memory-side signals of the
// fetch request sequencer. The sequencer connects through the master
// modport; the fetch stage / memory environment connects through slave.
//
// Handshake semantics:
//   - Memory request: imem_req_o is the valid, imem_gnt_i is the ready.
//     A request transfers on a cycle where both are high. While req is
//     high without grant, imem_addr_o holds.
//   - Memory response: imem_rvalid_i has no back-pressure; one word per
//     rvalid cycle, in request order.
//   - Fetch delivery: inst_valid_o is the valid, !stall_i is the ready.
//     A word transfers on a cycle where inst_valid_o && !stall_i; while
//     stalled, inst_o / inst_pc_o hold.
//
// Signals (named from the sequencer's point of view):
//   stall_i, redirect_i, redirect_pc_i, jump_i, jump_target_i  fetch control
//   imem_req_o, imem_addr_o, imem_gnt_i                         request channel
//   imem_rvalid_i, imem_rdata_i                                 response channel
//   inst_valid_o, inst_o, inst_pc_o                             fetch delivery
interface fetch_request_sequencer_if #(
  parameter int size = 32
);
  logic            stall_i;
  logic            redirect_i;
  logic [size-1:0] redirect_pc_i;
  logic            jump_i;
  logic [size-1:0] jump_target_i;
  logic            imem_req_o;
  logic [size-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [size-1:0] imem_rdata_i;
  logic            inst_valid_o;
  logic [size-1:0] inst_o;
  logic [size-1:0] inst_pc_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, jump_i, jump_target_i,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output inst_valid_o, inst_o, inst_pc_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, jump_i, jump_target_i,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  inst_valid_o, inst_o, inst_pc_o
  );
endinterface

// File: rtl/fetch_request_sequencer.sv
// Fetch request sequencer.
//
// Owns the fetch PC, issues credit-limited requests to instruction memory,
// buffers returned words with their PC and presents them to the fetch stage.
// Wrong-path words are squashed after a redirect or a taken jump prediction.
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous reset, active low
//   bus      fetch_request_sequencer_if.master (fetch control, imem, delivery)
//   state_o  debug view of the FSM state (0 IDLE, 1 RUN, 2 FLUSH)
module fetch_request_sequencer #(
  parameter int              size      = 32,
  parameter int              BUF_DEPTH = 2,
  parameter logic [size-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  fetch_request_sequencer_if.master        bus,
  output logic [1:0]                       state_o
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [size-1:0] pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q;

  // One slot ring shared by the PC queue and the word FIFO. A slot is
  // allocated at grant (PC written), filled at response (word written) and
  // released at pop. Credits keep allocated slots <= BUF_DEPTH, so the
  // three pointers never overtake each other.
  logic [size-1:0] pc_mem   [BUF_DEPTH];
  logic [size-1:0] word_mem [BUF_DEPTH];
  logic [PW-1:0]   alloc_ptr_q, fill_ptr_q, head_ptr_q;

  logic inst_valid, pop, squash, credit_ok, req, grant, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inst_valid    = (count_q != '0);
    pop           = inst_valid && !bus.stall_i;
    // The jumping instruction itself is delivered; only younger words die.
    squash        = bus.redirect_i || (pop && bus.jump_i);
    credit_ok     = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(BUF_DEPTH);
    req           = (state_q == ST_RUN) && !squash && credit_ok;
    grant         = req && bus.imem_gnt_i;
    // In FLUSH every returning word belongs to the wrong path.
    push          = (state_q == ST_RUN) && bus.imem_rvalid_i;
    outstanding_d = outstanding_q + CW'(grant) - CW'(bus.imem_rvalid_i);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (squash && (outstanding_d != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (outstanding_q == '0) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      head_ptr_q    <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;

      if (squash) begin
        pc_q <= bus.redirect_i ? bus.redirect_pc_i : bus.jump_target_i;
      end else if (grant) begin
        pc_q <= pc_q + size'(4);
      end

      if (squash) begin
        count_q     <= '0;
        alloc_ptr_q <= '0;
        fill_ptr_q  <= '0;
        head_ptr_q  <= '0;
      end else begin
        count_q <= count_q + CW'(push) - CW'(pop);
        if (grant) alloc_ptr_q <= ptr_inc(alloc_ptr_q);
        if (push)  fill_ptr_q  <= ptr_inc(fill_ptr_q);
        if (pop)   head_ptr_q  <= ptr_inc(head_ptr_q);
      end
    end
  end

  // Storage needs no reset: count_q gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (grant) pc_mem[alloc_ptr_q]  <= pc_q;
    if (push)  word_mem[fill_ptr_q] <= bus.imem_rdata_i;
  end

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = pc_q;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = word_mem[head_ptr_q];
  assign bus.inst_pc_o    = pc_mem[head_ptr_q];
  assign state_o          = state_q;

  // A response with nothing in flight means the memory broke protocol.
  rvalid_has_credit: assert property (
    @(posedge clk) disable iff (!reset) bus.imem_rvalid_i |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_request_sequencer.sv
// Testbench for fetch_request_sequencer.
module tb_fetch_request_sequencer;

  localparam int DEPTH = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;

  typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [1:0] state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_request_sequencer_if #(.size(32)) bus ();

  fetch_request_sequencer #(
    .size(32), .BUF_DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(state_o)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 1;
  mreq_t       mem_q[$];
  int          m_mode;
  logic [31:0] m_pc;
  int          m_out;
  ent_t        m_fifo[$];
  logic [31:0] exp_q[$];     // PCs granted and not yet returned

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_inst, obs_pc;
  logic [1:0]  obs_state;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 32'h0;
    m_out  = 0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  // One clock cycle: memory drives its response, outputs are compared with
  // the model, the model advances, then the clock edge passes.
  task automatic cycle();
    bit   rv, evalid, pop, sq, ereq, grant;
    int   out_next;
    ent_t e;
    if (!reset) begin
      model_reset();
      mem_q.delete();
    end
    rv = 1'b0;
    if (reset && mem_q.size() > 0) rv = (mem_q[0].due <= cyc);
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = 32'h0;
    if (rv) bus.imem_rdata_i = word_of(mem_q[0].addr);
    #1;
    evalid = m_fifo.size() > 0;
    pop    = evalid && !bus.stall_i;
    sq     = bus.redirect_i || (pop && bus.jump_i);
    ereq   = (m_mode == M_RUN) && !sq && (m_out + m_fifo.size() < DEPTH);

    obs_req   = bus.imem_req_o;
    obs_addr  = bus.imem_addr_o;
    obs_valid = bus.inst_valid_o;
    obs_inst  = bus.inst_o;
    obs_pc    = bus.inst_pc_o;
    obs_state = state_o;

    chk("req", obs_req, ereq);
    chk("addr", obs_addr, m_pc);
    chk("inst_valid", obs_valid, evalid);
    chk("state", obs_state, m_mode);
    if (evalid) begin
      chk("inst", obs_inst, m_fifo[0].word);
      chk("inst_pc", obs_pc, m_fifo[0].pc);
    end

    if (reset) begin
      grant    = ereq && bus.imem_gnt_i;
      out_next = m_out + int'(grant) - int'(rv);
      if (pop) void'(m_fifo.pop_front());
      if (rv && m_mode == M_RUN) begin
        e.word = bus.imem_rdata_i;
        e.pc   = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        m_fifo.push_back(e);
      end
      if (grant) exp_q.push_back(m_pc);
      if (sq) begin
        m_fifo.delete();
        exp_q.delete();
        m_pc = bus.redirect_i ? bus.redirect_pc_i : bus.jump_target_i;
      end else if (grant) begin
        m_pc = m_pc + 32'd4;
      end
      case (m_mode)
        M_IDLE:  m_mode = M_RUN;
        M_RUN:   if (sq && out_next > 0) m_mode = M_FLUSH;
        default: if (m_out == 0) m_mode = M_RUN;
      endcase
      m_out = out_next;
      if (rv) void'(mem_q.pop_front());
      if (obs_req && bus.imem_gnt_i) mem_q.push_back('{addr: obs_addr, due: cyc + lat});
    end

    @(posedge clk);
    #1;
    bus.redirect_i = 1'b0;
    bus.jump_i     = 1'b0;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    #1;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_req) begin found = 1'b1; break; end
    end
    chk({name, "_req_seen"}, found, 1'b1);
    if (found) chk({name, "_req_addr"}, obs_addr, exp);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_valid) begin found = 1'b1; break; end
    end
    chk({name, "_valid_seen"}, found, 1'b1);
    if (found) chk({name, "_valid_pc"}, obs_pc, exp_pc);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [15:0] pat_s;
    logic [15:0] pat_g;
    bit          saw_valid;
    bit          found;

    reset             = 1'b0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.jump_i        = 1'b0;
    bus.jump_target_i = 32'h0;
    bus.imem_gnt_i    = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    model_reset();
    @(posedge clk);
    #1;

    // T1: streaming start after reset release
    lat = 1;
    cycle();
    cycle();
    chk("rst_req", obs_req, 1'b0);
    chk("rst_valid", obs_valid, 1'b0);
    chk("rst_addr", obs_addr, 32'h0);
    reset = 1'b1;
    cycle();
    chk("t1_dead_cycle", obs_req, 1'b0);
    cycle();
    chk("t1_req0", obs_req, 1'b1);
    chk("t1_addr0", obs_addr, 32'h0);
    cycle();
    chk("t1_addr1", obs_addr, 32'h4);
    chk("t1_no_valid_yet", obs_valid, 1'b0);
    cycle();
    chk("t1_first_valid", obs_valid, 1'b1);
    chk("t1_first_pc", obs_pc, 32'h0);
    chk("t1_first_inst", obs_inst, 32'h1357_9BDF);
    repeat (6) cycle();

    // T2: stall fills the buffer, head holds, resume
    do_reset();
    bus.stall_i = 1'b1;
    repeat (7) cycle();
    chk("t2_stalled_req", obs_req, 1'b0);
    chk("t2_stalled_valid", obs_valid, 1'b1);
    chk("t2_stalled_pc", obs_pc, 32'h0);
    bus.stall_i = 1'b0;
    cycle();
    chk("t2_resume_pc", obs_pc, 32'h0);
    chk("t2_resume_req", obs_req, 1'b0);
    cycle();
    chk("t2_next_req", obs_req, 1'b1);
    chk("t2_next_addr", obs_addr, 32'h8);
    chk("t2_next_pc", obs_pc, 32'h4);
    repeat (4) cycle();

    // T3: redirect with two requests outstanding
    do_reset();
    lat = 3;
    repeat (3) cycle();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    cycle();
    chk("t3_squash_req", obs_req, 1'b0);
    cycle();
    chk("t3_flush_state", obs_state, 2'd2);
    saw_valid = obs_valid;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      saw_valid = saw_valid | obs_valid;
      if (obs_req) begin found = 1'b1; break; end
    end
    chk("t3_req_seen", found, 1'b1);
    chk("t3_req_addr", obs_addr, 32'h100);
    chk("t3_no_wrong_path", saw_valid, 1'b0);
    repeat (6) cycle();

    // T4: taken jump on head 0x8 drops younger buffered word
    do_reset();
    lat = 1;
    for (int i = 0; i < 40 && !(m_fifo.size() > 0 && m_fifo[0].pc == 32'h8); i++) cycle();
    chk("t4_head8_reached", (m_fifo.size() > 0 && m_fifo[0].pc == 32'h8), 1'b1);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 10 && m_fifo.size() < DEPTH; i++) cycle();
    bus.stall_i       = 1'b0;
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h40;
    cycle();
    chk("t4_jump_valid", obs_valid, 1'b1);
    chk("t4_jump_pc", obs_pc, 32'h8);
    wait_req("t4", 32'h40);
    wait_valid("t4", 32'h40);

    // T5: redirect beats jump in the same cycle
    for (int i = 0; i < 20 && m_fifo.size() == 0; i++) cycle();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h40;
    cycle();
    wait_req("t5", 32'h200);
    wait_valid("t5", 32'h200);

    // T7: irregular grant and stall patterns with a redirect and a jump
    lat   = 2;
    pat_s = 16'b0011_0000_1100_0100;
    pat_g = 16'b1101_1011_1110_0111;
    for (int i = 0; i < 48; i++) begin
      bus.stall_i    = pat_s[i % 16];
      bus.imem_gnt_i = pat_g[i % 16];
      if (i == 21) begin
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h300;
      end
      if (i == 33) begin
        bus.jump_i        = 1'b1;
        bus.jump_target_i = 32'h80;
      end
      cycle();
    end
    bus.stall_i    = 1'b0;
    bus.imem_gnt_i = 1'b1;
    repeat (6) cycle();

    // T6: reset mid-stream
    reset = 1'b0;
    #1;
    chk("t6_req_low", bus.imem_req_o, 1'b0);
    chk("t6_valid_low", bus.inst_valid_o, 1'b0);
    chk("t6_addr_reset", bus.imem_addr_o, 32'h0);
    cycle();
    cycle();
    reset = 1'b1;
    lat = 1;
    cycle();
    chk("t6_dead_cycle", obs_req, 1'b0);
    cycle();
    chk("t6_restart_req", obs_req, 1'b1);
    chk("t6_restart_addr", obs_addr, 32'h0);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
